// File: rtl/conv3x3_engine_if.sv
// Handshake and data bus bundle for conv3x3_engine.
// The master drives the request, padded matrix and kernel; the slave (the engine)
// returns the result matrix together with its busy/done status.
interface conv3x3_engine_if #(
  parameter int INPUT_SIZE  = 16,
  parameter int OUTPUT_SIZE = INPUT_SIZE - 2,
  parameter int PIX_W       = 4,
  parameter int W_W         = 4,
  parameter int ACC_W       = 13
);
  logic                                     start;
  logic [INPUT_SIZE*INPUT_SIZE*PIX_W-1:0]   input_matrix;
  logic [9*W_W-1:0]                         kernel;
  logic [OUTPUT_SIZE*OUTPUT_SIZE*ACC_W-1:0] output_matrix;
  logic                                     busy;
  logic                                     done;

  modport master (
    output start, input_matrix, kernel,
    input  output_matrix, busy, done
  );

  modport slave (
    input  start, input_matrix, kernel,
    output output_matrix, busy, done
  );
endinterface

// File: rtl/conv3x3_engine.sv
// conv3x3_engine: sequential 3x3 convolution (stride 1) over a padded square matrix
// of unsigned pixels with a signed 9-tap kernel, one multiply-accumulate per cycle.
// Optional feature macro: CONV_RELU_EN -- when defined, negative results are written
// as zero; when undefined, the raw two's-complement sum is written.
module conv3x3_engine #(
  parameter int INPUT_SIZE  = 16,
  parameter int OUTPUT_SIZE = INPUT_SIZE - 2,
  parameter int PIX_W       = 4,
  parameter int W_W         = 4,
  parameter int ACC_W       = 13
) (
  input  logic             clk,
  input  logic             rst,
  conv3x3_engine_if.slave  bus
);

  localparam int NPIX   = INPUT_SIZE * INPUT_SIZE;
  localparam int NOUT   = OUTPUT_SIZE * OUTPUT_SIZE;
  localparam int PI_W   = $clog2(NPIX);
  localparam int OI_W   = $clog2(NOUT);
  localparam int RC_W   = $clog2(OUTPUT_SIZE);
  localparam int PR_W   = $clog2(INPUT_SIZE);
  localparam int PROD_W = PIX_W + W_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                             r_state;
  logic [NPIX-1:0][PIX_W-1:0]         r_pix;
  logic [8:0][W_W-1:0]                r_kern;
  logic [NOUT-1:0][ACC_W-1:0]         r_out;
  logic [RC_W-1:0]                    r_row;
  logic [RC_W-1:0]                    r_col;
  logic [3:0]                         r_tap;
  logic [ACC_W-1:0]                   r_acc;
  logic                               r_busy;
  logic                               r_done;

  logic [1:0]                         w_kr;
  logic [1:0]                         w_kc;
  logic [PR_W-1:0]                    w_pixRow;
  logic [PR_W-1:0]                    w_pixCol;
  logic [PI_W-1:0]                    w_pixIdx;
  logic [OI_W-1:0]                    w_outIdx;
  logic [PIX_W-1:0]                   w_pix;
  logic [W_W-1:0]                     w_wt;
  logic signed [PROD_W-1:0]           w_prod;
  logic [ACC_W-1:0]                   w_prodExt;
  logic [ACC_W-1:0]                   w_accNext;
  logic [ACC_W-1:0]                   w_wrVal;
  logic                               w_lastTap;
  logic                               w_lastCol;
  logic                               w_lastRow;

  // Split the tap counter into kernel row/column (taps run kr-major).
  always_comb begin
    w_kr = 2'd0;
    w_kc = 2'd0;
    case (r_tap)
      4'd0: begin w_kr = 2'd0; w_kc = 2'd0; end
      4'd1: begin w_kr = 2'd0; w_kc = 2'd1; end
      4'd2: begin w_kr = 2'd0; w_kc = 2'd2; end
      4'd3: begin w_kr = 2'd1; w_kc = 2'd0; end
      4'd4: begin w_kr = 2'd1; w_kc = 2'd1; end
      4'd5: begin w_kr = 2'd1; w_kc = 2'd2; end
      4'd6: begin w_kr = 2'd2; w_kc = 2'd0; end
      4'd7: begin w_kr = 2'd2; w_kc = 2'd1; end
      4'd8: begin w_kr = 2'd2; w_kc = 2'd2; end
      default: begin w_kr = 2'd0; w_kc = 2'd0; end
    endcase
  end

  assign w_pixRow  = PR_W'(r_row) + PR_W'(w_kr);
  assign w_pixCol  = PR_W'(r_col) + PR_W'(w_kc);
  assign w_pixIdx  = PI_W'(w_pixRow) * PI_W'(INPUT_SIZE) + PI_W'(w_pixCol);
  assign w_outIdx  = OI_W'(r_row) * OI_W'(OUTPUT_SIZE) + OI_W'(r_col);
  assign w_pix     = r_pix[w_pixIdx];
  assign w_wt      = r_kern[r_tap];

  // The pixel is treated as a non-negative signed value so the product keeps the weight's sign.
  assign w_prod    = $signed({1'b0, w_pix}) * $signed(w_wt);
  assign w_prodExt = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
  assign w_accNext = r_acc + w_prodExt;

  assign w_lastTap = (r_tap == 4'd8);
  assign w_lastCol = (r_col == RC_W'(OUTPUT_SIZE - 1));
  assign w_lastRow = (r_row == RC_W'(OUTPUT_SIZE - 1));

  // Value stored into the result element; the optional rectifier only affects the stored copy.
  always_comb begin
    w_wrVal = w_accNext;
`ifdef CONV_RELU_EN
    if (w_accNext[ACC_W-1]) begin
      w_wrVal = '0;
    end
`endif
  end

  // Control FSM with counters, accumulator, latched operands and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_pix   <= '0;
      r_kern  <= '0;
      r_out   <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_tap   <= '0;
      r_acc   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_pix   <= bus.input_matrix;
            r_kern  <= bus.kernel;
            r_row   <= '0;
            r_col   <= '0;
            r_tap   <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (w_lastTap) begin
            r_out[w_outIdx] <= w_wrVal;
            r_acc <= '0;
            r_tap <= '0;
            if (w_lastCol) begin
              r_col <= '0;
              if (w_lastRow) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= DONE;
              end else begin
                r_row <= r_row + 1'b1;
              end
            end else begin
              r_col <= r_col + 1'b1;
            end
          end else begin
            r_acc <= w_accNext;
            r_tap <= r_tap + 1'b1;
          end
        end
        DONE: begin
          if (!bus.start) begin
            r_done  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.output_matrix = r_out;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;

endmodule

// File: tb/tb_conv3x3_engine.sv
// Self-checking bench for conv3x3_engine: directed test-plan cases plus randomized
// matrices/kernels compared against a plain-arithmetic convolution model.
module tb_conv3x3_engine;

  localparam int IS = 16;
  localparam int OS = IS - 2;
  localparam int PW = 4;
  localparam int WW = 4;
  localparam int AW = 13;
  localparam int RUNLEN = OS * OS * 9;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   pix [IS][IS];
  int   kern [9];
  int   expEl [OS*OS];
  int   lat;

  conv3x3_engine_if #(.INPUT_SIZE(IS), .OUTPUT_SIZE(OS), .PIX_W(PW), .W_W(WW), .ACC_W(AW)) bus ();

  conv3x3_engine #(.INPUT_SIZE(IS), .OUTPUT_SIZE(OS), .PIX_W(PW), .W_W(WW), .ACC_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] getEl(input int r, input int c);
    logic [AW-1:0] v;
    v = bus.output_matrix[(r*OS+c)*AW +: AW];
    return {{(32-AW){1'b0}}, v};
  endfunction

  // Drive the bus with the model's matrix and kernel.
  task automatic applyStimulus();
    for (int r = 0; r < IS; r++)
      for (int c = 0; c < IS; c++)
        bus.input_matrix[(r*IS+c)*PW +: PW] = PW'(pix[r][c]);
    for (int t = 0; t < 9; t++)
      bus.kernel[t*WW +: WW] = WW'(kern[t]);
  endtask

  // Reference convolution straight from the definition.
  task automatic buildExpected();
    int s;
    for (int r = 0; r < OS; r++)
      for (int c = 0; c < OS; c++) begin
        s = 0;
        for (int kr = 0; kr < 3; kr++)
          for (int kc = 0; kc < 3; kc++)
            s += pix[r+kr][c+kc] * kern[kr*3+kc];
`ifdef CONV_RELU_EN
        if (s < 0) s = 0;
`endif
        expEl[r*OS+c] = s & ((1 << AW) - 1);
      end
  endtask

  task automatic checkMatrix(input string tag);
    buildExpected();
    for (int k = 0; k < OS*OS; k++)
      checkOutput($sformatf("%s_el%0d", tag, k), getEl(k / OS, k % OS), 32'(expEl[k]));
  endtask

  task automatic randomizeBusInputs();
    for (int i = 0; i < IS*IS; i++) bus.input_matrix[i*PW +: PW] = PW'($urandom);
    for (int t = 0; t < 9; t++) bus.kernel[t*WW +: WW] = WW'($urandom);
  endtask

  // Issue a start and wait (bounded) for done; latency counts edges after acceptance.
  task automatic runConv(input bit dropStart, input bit disturb, output int latOut);
    int n;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("busyAfterAccept", {31'd0, bus.busy}, 32'd1);
    n = 0;
    while (bus.done !== 1'b1 && n < 3000) begin
      if (dropStart && n == 0) bus.start = 1'b0;
      if (disturb && n >= 3 && n < 1500 && (n % 97) == 0) begin
        bus.start = ~bus.start;
        randomizeBusInputs();
      end
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("runLatency", 32'(n), 32'(RUNLEN));
    latOut = n;
  endtask

  // Release start and confirm the engine drops done after one edge.
  task automatic finishRun(input string tag);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput({tag, "_doneLow"}, {31'd0, bus.done}, 32'd0);
    checkOutput({tag, "_busyLow"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.input_matrix = '0;
    bus.kernel = '0;

    // Reset state.
    #23;
    checkOutput("rstBusy", {31'd0, bus.busy}, 32'd0);
    checkOutput("rstDone", {31'd0, bus.done}, 32'd0);
    for (int k = 0; k < OS*OS; k++)
      checkOutput($sformatf("rstOut%0d", k), getEl(k / OS, k % OS), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Ones inside a zero border, all-ones kernel; start held high through DONE.
    for (int r = 0; r < IS; r++)
      for (int c = 0; c < IS; c++)
        pix[r][c] = (r == 0 || c == 0 || r == IS-1 || c == IS-1) ? 0 : 1;
    for (int t = 0; t < 9; t++) kern[t] = 1;
    applyStimulus();
    runConv(1'b0, 1'b0, lat);
    checkOutput("ones_00", getEl(0, 0), 32'd4);
    checkOutput("ones_05", getEl(0, 5), 32'd6);
    checkOutput("ones_55", getEl(5, 5), 32'd9);
    checkOutput("ones_1313", getEl(13, 13), 32'd4);
    checkMatrix("ones");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("holdDone", {31'd0, bus.done}, 32'd1);
    end
    finishRun("hold");

    // Identity kernel over a random padded 14x14 pattern.
    for (int r = 0; r < IS; r++)
      for (int c = 0; c < IS; c++)
        pix[r][c] = (r == 0 || c == 0 || r == IS-1 || c == IS-1) ? 0 : int'($urandom_range(15));
    for (int t = 0; t < 9; t++) kern[t] = (t == 4) ? 1 : 0;
    applyStimulus();
    runConv(1'b0, 1'b0, lat);
    for (int k = 0; k < OS*OS; k += 13)
      checkOutput($sformatf("ident%0d", k), getEl(k / OS, k % OS), 32'(pix[k/OS+1][k%OS+1]));
    checkMatrix("ident");
    finishRun("ident");

    // Worst-case negative sum; start dropped right after acceptance gives a one-cycle done.
    for (int r = 0; r < IS; r++)
      for (int c = 0; c < IS; c++) pix[r][c] = 15;
    for (int t = 0; t < 9; t++) kern[t] = -8;
    applyStimulus();
    runConv(1'b1, 1'b0, lat);
`ifdef CONV_RELU_EN
    checkOutput("neg_00", getEl(0, 0), 32'h0);
    checkOutput("neg_1313", getEl(13, 13), 32'h0);
`else
    checkOutput("neg_00", getEl(0, 0), 32'h1BC8);
    checkOutput("neg_1313", getEl(13, 13), 32'h1BC8);
`endif
    checkMatrix("neg");
    @(posedge clk);
    #1;
    checkOutput("pulseDone", {31'd0, bus.done}, 32'd0);

    // Random data; start toggled and inputs scrambled during the run.
    for (int r = 0; r < IS; r++)
      for (int c = 0; c < IS; c++) pix[r][c] = int'($urandom_range(15));
    for (int t = 0; t < 9; t++) kern[t] = int'($urandom_range(15)) - 8;
    applyStimulus();
    runConv(1'b0, 1'b1, lat);
    checkMatrix("disturb");
    finishRun("disturb");

    // Asynchronous reset 500 cycles into a run, then a fresh full run.
    for (int r = 0; r < IS; r++)
      for (int c = 0; c < IS; c++) pix[r][c] = int'($urandom_range(15));
    for (int t = 0; t < 9; t++) kern[t] = int'($urandom_range(15)) - 8;
    applyStimulus();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    repeat (500) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("abortBusy", {31'd0, bus.busy}, 32'd0);
    checkOutput("abortDone", {31'd0, bus.done}, 32'd0);
    for (int k = 0; k < OS*OS; k++)
      checkOutput($sformatf("abortOut%0d", k), getEl(k / OS, k % OS), 32'd0);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int r = 0; r < IS; r++)
      for (int c = 0; c < IS; c++) pix[r][c] = int'($urandom_range(15));
    for (int t = 0; t < 9; t++) kern[t] = int'($urandom_range(15)) - 8;
    applyStimulus();
    runConv(1'b0, 1'b0, lat);
    checkMatrix("restart");
    finishRun("restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv3x3_engine.md
# conv3x3_engine

Sequential 3x3 convolution stage placed directly downstream of the zero-padding block. Consumes the padded INPUT_SIZE x INPUT_SIZE matrix of unsigned 4-bit pixels as a flattened bus. Convolves it (stride 1, no further padding) with a 9-tap signed kernel using a single multiply-accumulate unit. Presents the (INPUT_SIZE-2) x (INPUT_SIZE-2) result as a flattened bus under the same level start/done handshake as the padding stage.

## Interface
- INPUT_SIZE, 16: padded matrix side (padding stage OUTPUT_SIZE)
- OUTPUT_SIZE, INPUT_SIZE-2: result matrix side
- PIX_W, 4: unsigned pixel width
- W_W, 4: signed kernel weight width
- ACC_W, 13: signed result width per output element
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  level request; sampled only in IDLE
- input_matrix  in  INPUT_SIZE*INPUT_SIZE*PIX_W  element (r,c) at [(r*INPUT_SIZE+c)*PIX_W +: PIX_W]
- kernel  in  9*W_W  tap (kr,kc) at [(kr*3+kc)*W_W +: W_W], two's complement
- output_matrix  out  OUTPUT_SIZE*OUTPUT_SIZE*ACC_W  element (r,c) at [(r*OUTPUT_SIZE+c)*ACC_W +: ACC_W]
- busy  out  1  high while in RUN
- done  out  1  high while in DONE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at an edge:
  - latch input_matrix and kernel into internal registers
  - clear row, column, tap counters and accumulator
  - go to RUN
- RUN, one tap per cycle, taps in order kr-major (0..8):
  - acc_next = acc + pix(r+kr, c+kc) * w(kr,kc)
  - pixel zero-extended to PIX_W+1 signed; product sign-extended to ACC_W
- Tap 8 of a pixel:
  - write acc_next to output element (r,c)
  - clear acc; advance c, wrapping to 0 with r+1
- Tap 8 of pixel (OUTPUT_SIZE-1, OUTPUT_SIZE-1): go to DONE.
- DONE: stay while start=1; go to IDLE on the first edge with start=0.
- start during RUN or DONE: ignored. No new run until IDLE.
- Input bus changes after acceptance: no effect (latched copy used).
- output_matrix holds prior values until overwritten; contents valid only while done=1.
- ACC_W=13 covers the worst case 9*15*8=1080 with no overflow. No saturation logic; widths below 12 are unsupported.

## Timing
- Reset (rst=0, async): state IDLE, busy=0, done=0, output_matrix=0, all counters and acc=0, latched copies=0.
- Acceptance edge E0: busy=1 after E0.
- Run length: OUTPUT_SIZE*OUTPUT_SIZE*9 edges (1764 at defaults).
- After edge E1764: busy=0, done=1, output_matrix complete.
- done is a registered state decode: it deasserts one edge after start is seen low in DONE.
- start already low at DONE entry: done is a one-cycle pulse.
- Output element (r,c) is final 9*(r*OUTPUT_SIZE+c+1) edges after E0.
- rst asserted mid-RUN: immediate abort, all outputs zero. A new start after release runs the full length.

## Configuration
- CONV_RELU_EN defined: a negative acc_next is written as 0; non-negative values pass unchanged. Accumulation itself is unclamped.
- Not defined: raw two's-complement result written.

## Test plan
- Padded 16x16 (zero border, ones inside), kernel all +1 -> out(0,0)=4, out(0,5)=6, out(5,5)=9, out(13,13)=4.
- Identity kernel (tap 4 = 1, others 0), 14x14 test pattern padded -> output equals unpadded pattern exactly; done exactly 1764 cycles after acceptance.
- All pixels 15, all weights -8 -> every element 0x1BC8 (-1080); with CONV_RELU_EN every element 0.
- rst=0 at cycle 500 of RUN -> busy, done, output_matrix 0 asynchronously. Restart -> correct result after 1764 cycles.
- Handshake checks:
  - start held through DONE -> done stays 1; start low -> done 0 after next edge
  - start low at DONE entry -> one-cycle done
  - start toggled and input_matrix/kernel changed during RUN -> result unchanged
